gray_to_bin: RTL and testbench
==============================

GRAY_TO_BIN -- requirements
Module: gray_to_bin

Interface
REQ-001 Parameter WIDTH, default 4: code width in bits; legal range 2..16.
REQ-002 Clock and reset: clk, 1-bit input, rising-edge clock for all state; rst, 1-bit input, reset, synchronous, active-low.
REQ-003 in_valid  input  1  Gray word on in_gray is offered.
REQ-004 in_gray  input  WIDTH  Gray-coded input word.
REQ-005 in_ready  output  1  Block can accept a word this cycle.
REQ-006 out_valid  output  1  out_* fields hold a decoded result.
REQ-007 out_ready  input  1  Downstream accepts the result this cycle.
REQ-008 out_bin  output  WIDTH  Decoded natural binary value.
REQ-009 out_step_err  output  1  This word differs from the previous accepted word in more than one bit.
REQ-010 out_hold  output  1  This word equals the previous accepted word.
REQ-011 out_dir  output  1  Step direction: 1 = up (+1 mod 2^WIDTH), 0 = down (-1 mod 2^WIDTH).
REQ-012 err_count  output  8  Saturating count of accepted words with step error.

Function
REQ-013 Decode: out_bin[WIDTH-1] = in_gray[WIDTH-1]; for i < WIDTH-1, out_bin[i] = out_bin[i+1] XOR in_gray[i].
REQ-014 Accept event: an input word is accepted in a cycle when in_valid=1 and in_ready=1.
REQ-015 in_ready: in_ready = (!out_valid) OR out_ready, combinational; no combinational path from in_valid to in_ready.
REQ-016 Latency: an accepted word appears on out_* with out_valid=1 on the next rising edge (1 cycle).
REQ-017 Output stability: while out_valid=1 and out_ready=0, all out_* fields hold stable.
REQ-018 Output clear: when out_ready=1 and no accept occurs, out_valid clears to 0 at the next edge.
REQ-019 Back-to-back transfer: accept and output drain in the same cycle sustain 1 word per cycle.
REQ-020 Reference word: the block keeps the last accepted Gray word and a first flag, set at reset and cleared on the first accept.
REQ-021 First word after reset: out_step_err=0, out_hold=0, out_dir=0, and err_count is unchanged.
REQ-022 Step classification: Hamming distance from the reference word:
- distance 0 → out_hold=1, out_step_err=0;
- distance 1 → both 0;
- distance ≥2 → out_step_err=1, out_hold=0.
REQ-023 out_dir: 1 if new bin == (previous bin + 1) mod 2^WIDTH, else 0; forced 0 when out_hold=1 or out_step_err=1.
REQ-024 Wrap-around: max-code-to-zero (WIDTH=4: Gray 1000 → 0000) is a legal step with out_dir=1; the reverse is legal with out_dir=0.
REQ-025 Reference update: updates on every accept, including step-error words.
REQ-026 err_count increments by 1 on each accepted step-error word and saturates at 255, never wrapping.
REQ-027 Stalled input: the block accepts no input when in_ready=0; a held in_valid is accepted only once, on the cycle in_ready=1.

Reset
REQ-028 When rst=0 at a rising edge, the block shall clear the following: out_valid=0, out_bin=0, out_step_err=0, out_hold=0, out_dir=0, err_count=0.
REQ-029 The same reset edge shall clear the reference word to 0 and set the first flag.
REQ-030 Reset shall take priority over any accept or drain in the same cycle; a word in flight is discarded.

Verification
REQ-031 Basic decode: WIDTH=4, out_ready=1, in_gray=0110 accepted → next cycle out_valid=1, out_bin=0100, out_step_err=0.
REQ-032 Exhaustive counting: gray sequence 0000, 0001, 0011, 0010, …, 1000, 0000 → out_bin 0..15 then 0, out_dir=1 from the second word onward, err_count=0 throughout.
REQ-033 Step error and repeat: 0000 then 0011 → out_step_err=1, err_count=1; then 0011 again → out_hold=1, out_step_err=0, err_count stays 1.
REQ-034 Backpressure: out_ready=0 with a word held, in_valid=1 with 0101 → in_ready=0, out_bin stable for 5 cycles; raising out_ready drains the held word, then 0101 is accepted and out_bin=0110 next cycle.
REQ-035 Saturation: 300 accepted step-error words → err_count=255 and stays 255.
REQ-036 Reset mid-operation: rst=0 while out_valid=1 → next cycle out_valid=0, err_count=0; the first word after release reports out_step_err=0.

Source files
------------

// File: rtl/gray_to_bin.sv
// Gray-to-binary decoder that classifies each accepted word against the previous accepted one.
// Latency: 1 cycle from accept to out_valid; one result register, so it sustains 1 word/cycle.
// Backpressure: in_ready = !out_valid | out_ready; a stalled result holds all out_* fields stable.
module gray_to_bin #(
    parameter int WIDTH = 4  // code width, meaningful for 2..16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_gray,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_step_err,
    output logic             out_hold,
    output logic             out_dir,
    output logic [7:0]       err_count
);

    // Each binary bit is the XOR of the Gray bits at and above it.
    function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [WIDTH-1:0] ref_gray;    // last accepted Gray word
    logic             first_word;  // no word accepted since reset
    logic [WIDTH-1:0] nxt_bin;
    logic [WIDTH-1:0] prev_bin;
    logic [WIDTH-1:0] diff;
    logic             one_bit;
    logic             step_hold;
    logic             step_err;
    logic             step_dir;
    logic             accept;

    // Ready depends only on the output register state, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Decode the offered word and classify it against the reference word.
    always_comb begin
        nxt_bin   = gray_decode(in_gray);
        prev_bin  = gray_decode(ref_gray);
        diff      = in_gray ^ ref_gray;
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
        step_hold = 1'b0;
        step_err  = 1'b0;
        step_dir  = 1'b0;
        if (!first_word) begin
            step_hold = (diff == '0);
            step_err  = (diff != '0) && !one_bit;
            // Wrap from max code to zero falls out of the modulo addition.
            step_dir  = one_bit && (nxt_bin == prev_bin + WIDTH'(1));
        end
    end

    // Result register, reference word and saturating error counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_bin      <= '0;
            out_step_err <= 1'b0;
            out_hold     <= 1'b0;
            out_dir      <= 1'b0;
            err_count    <= 8'd0;
            ref_gray     <= '0;
            first_word   <= 1'b1;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_bin      <= nxt_bin;
            out_step_err <= step_err;
            out_hold     <= step_hold;
            out_dir      <= step_dir;
            ref_gray     <= in_gray;
            first_word   <= 1'b0;
            if (step_err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_to_bin.sv
// Randomised and directed checks of gray_to_bin against a value-level transaction model.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: out_ready is driven per cycle, expected acceptance derived from the model's valid state.
module tb_gray_to_bin;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_gray = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_bin;
    logic         out_step_err;
    logic         out_hold;
    logic         out_dir;
    logic [7:0]   err_count;

    always #5 clk = ~clk;

    gray_to_bin #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_gray(in_gray), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_step_err(out_step_err), .out_hold(out_hold), .out_dir(out_dir),
        .err_count(err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model state.
    bit         m_first = 1'b1;
    int         m_ref   = 0;   // previous accepted Gray word
    bit         m_valid = 1'b0;
    int         m_bin   = 0;
    bit         m_err   = 1'b0;
    bit         m_hold  = 1'b0;
    bit         m_dir   = 1'b0;
    int         m_cnt   = 0;
    logic       rdy_seen;
    bit         rdy_exp;

    function automatic int to_gray(input int v);
        return (v ^ (v >> 1)) % (1 << W);
    endfunction

    // Decode by searching for the counter value whose Gray code matches.
    function automatic int from_gray(input int g);
        for (int v = 0; v < (1 << W); v++) begin
            if (to_gray(v) == g) return v;
        end
        return -1;
    endfunction

    function automatic logic [15:0] got_vec();
        return {out_valid, out_bin, out_step_err, out_hold, out_dir, err_count};
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_valid, 4'(m_bin), m_err, m_hold, m_dir, 8'(m_cnt)};
    endfunction

    // Drive one cycle, record in_ready before the edge, advance the model at the edge.
    task automatic tick(input bit v, input int g, input bit ordy, input bit r);
        int d;
        in_valid  = v;
        in_gray   = 4'(g);
        out_ready = ordy;
        rst       = r;
        #1;
        rdy_seen = in_ready;
        rdy_exp  = !m_valid || ordy;
        @(posedge clk);
        if (!r) begin
            m_first = 1'b1; m_ref = 0; m_valid = 1'b0; m_bin = 0;
            m_err = 1'b0; m_hold = 1'b0; m_dir = 1'b0; m_cnt = 0;
        end else if (v && rdy_exp) begin
            m_bin = from_gray(g);
            if (m_first) begin
                m_err = 1'b0; m_hold = 1'b0; m_dir = 1'b0;
            end else begin
                d      = $countones(4'(g ^ m_ref));
                m_hold = (d == 0);
                m_err  = (d >= 2);
                m_dir  = (d == 1) && (m_bin == (from_gray(m_ref) + 1) % (1 << W));
                if (m_err && m_cnt < 255) m_cnt++;
            end
            m_ref   = g;
            m_first = 1'b0;
            m_valid = 1'b1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 15, 1'b1, 1'b0);
        n_checks++;
        if (got_vec() !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got_vec(), 16'h0000);
        end
        tick(1'b0, 0, 1'b0, 1'b1);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic_decode();
        tick(1'b0, 0, 1'b1, 1'b0);
        tick(1'b1, 6, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_bin !== 4'b0100 || out_step_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_decode: got v=%b bin=%b err=%b expected v=1 bin=0100 err=0",
                     out_valid, out_bin, out_step_err);
        end
    endtask

    task automatic test_counting();
        tick(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i <= 16; i++) begin
            tick(1'b1, to_gray(i % 16), 1'b1, 1'b1);
            n_checks++;
            if (out_valid !== 1'b1 || out_bin !== 4'(i % 16) || out_dir !== (i > 0)
                || out_step_err !== 1'b0 || err_count !== 8'd0) begin
                n_fail++;
                $display("FAIL counting[%0d]: got v=%b bin=%0d dir=%b err=%b cnt=%0d expected v=1 bin=%0d dir=%b err=0 cnt=0",
                         i, out_valid, out_bin, out_dir, out_step_err, err_count, i % 16, i > 0);
            end
        end
    endtask

    task automatic test_step_err_hold();
        tick(1'b0, 0, 1'b1, 1'b0);
        tick(1'b1, 0, 1'b1, 1'b1);
        tick(1'b1, 3, 1'b1, 1'b1);
        n_checks++;
        if (out_step_err !== 1'b1 || out_hold !== 1'b0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL step_err: got err=%b hold=%b cnt=%0d expected err=1 hold=0 cnt=1",
                     out_step_err, out_hold, err_count);
        end
        tick(1'b1, 3, 1'b1, 1'b1);
        n_checks++;
        if (out_hold !== 1'b1 || out_step_err !== 1'b0 || out_dir !== 1'b0 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL repeat_hold: got hold=%b err=%b dir=%b cnt=%0d expected hold=1 err=0 dir=0 cnt=1",
                     out_hold, out_step_err, out_dir, err_count);
        end
    endtask

    task automatic test_backpressure();
        tick(1'b0, 0, 1'b1, 1'b0);
        tick(1'b1, 1, 1'b0, 1'b1);  // word held, bin 1
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 5, 1'b0, 1'b1);
            n_checks++;
            if (rdy_seen !== 1'b0 || out_valid !== 1'b1 || out_bin !== 4'd1) begin
                n_fail++;
                $display("FAIL stall[%0d]: got rdy=%b v=%b bin=%0d expected rdy=0 v=1 bin=1",
                         i, rdy_seen, out_valid, out_bin);
            end
        end
        // Drain and accept in the same cycle.
        tick(1'b1, 5, 1'b1, 1'b1);
        n_checks++;
        if (rdy_seen !== 1'b1 || out_valid !== 1'b1 || out_bin !== 4'b0110) begin
            n_fail++;
            $display("FAIL drain_accept: got rdy=%b v=%b bin=%b expected rdy=1 v=1 bin=0110",
                     rdy_seen, out_valid, out_bin);
        end
        // No new word: output clears.
        tick(1'b0, 0, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b0 || out_bin !== 4'b0110) begin
            n_fail++;
            $display("FAIL output_clear: got v=%b bin=%b expected v=0 bin=0110", out_valid, out_bin);
        end
    endtask

    task automatic test_saturation();
        tick(1'b0, 0, 1'b1, 1'b0);
        tick(1'b1, 0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, (i % 2 == 0) ? 3 : 0, 1'b1, 1'b1);
            if (i == 254 || i == 255 || i == 299) begin
                n_checks++;
                if (err_count !== 8'(m_cnt) || err_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL saturation[%0d]: got %0d expected 255", i, err_count);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 0, 1'b1, 1'b0);
        tick(1'b1, 0, 1'b1, 1'b1);
        tick(1'b1, 3, 1'b0, 1'b1);
        tick(1'b1, 6, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, err_count);
        end
        tick(1'b1, 15, 1'b1, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_step_err !== 1'b0 || out_hold !== 1'b0
            || out_dir !== 1'b0 || out_bin !== 4'd10) begin
            n_fail++;
            $display("FAIL first_after_reset: got v=%b err=%b hold=%b dir=%b bin=%0d expected v=1 err=0 hold=0 dir=0 bin=10",
                     out_valid, out_step_err, out_hold, out_dir, out_bin);
        end
    endtask

    task automatic test_random();
        int g;
        int sel;
        tick(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      g = $urandom_range(0, 15);
            else if (sel == 1) g = m_ref;
            else if (sel == 2) g = to_gray((from_gray(m_ref) + 1) % 16);
            else               g = to_gray((from_gray(m_ref) + 15) % 16);
            tick(($urandom_range(0, 3) != 0), g, ($urandom_range(0, 9) < 7), 1'b1);
            n_checks++;
            if (rdy_seen !== rdy_exp || got_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got rdy=%b out=%h expected rdy=%b out=%h",
                         i, rdy_seen, got_vec(), rdy_exp, exp_vec());
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic_decode();
        test_counting();
        test_step_err_hold();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
